md_ctrl: RTL and testbench

Issue and hazard controller for the iterative multiply/divide unit in the E stage of the pipelined MIPS core. Decodes the E-stage HI/LO operation into the unit's start/op controls and tracks the in-flight operation with its own latency counter. Stalls the D stage while a HI/LO-dependent instruction would see stale HI/LO. Cross-checks its counter against the unit's busy flag and counts stall cycles for performance readout.

---
 rtl/md_ctrl.sv | 105 ++++++++++
 tb/tb_md_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// md_ctrl: issue and hazard controller for the iterative mult/div unit.
// Decodes the E-stage HI/LO op, tracks unit latency and stalls D on hazards.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   d_md_use       D-stage instruction touches HI/LO or the unit
//   e_md_valid     E-stage instruction is a HI/LO writer
//   e_md_op        0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
//   e_flush        E-stage instruction is killed this cycle
//   md_busy        busy flag reported by the unit
//   md_start       start pulse to the unit (combinational)
//   md_op          op code to the unit, 7 when idle (combinational)
//   md_stall       freeze PC/F/D and bubble E (combinational)
//   md_cycles_left remaining busy cycles, 0 when idle
//   md_err         sticky controller/unit busy mismatch
//   stall_cnt      saturating count of stalled cycles
module md_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        d_md_use,
   input  logic        e_md_valid,
   input  logic [2:0]  e_md_op,
   input  logic        e_flush,
   input  logic        md_busy,
   output logic        md_start,
   output logic [2:0]  md_op,
   output logic        md_stall,
   output logic [3:0]  md_cycles_left,
   output logic        md_err,
   output logic [15:0] stall_cnt
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;
   logic       armed, armed_n;
   logic       go, run, issue;

   assign go    = e_md_valid & ~e_flush;
   assign run   = (state == RUN);
   assign issue = go & ~run & (e_md_op <= 3'd3);

   // State register plus the sticky error and stall counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         armed     <= 1'b0;
         md_err    <= 1'b0;
         stall_cnt <= 16'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         armed <= armed_n;
         // The unit ignores reset, so the cross-check waits for the
         // first issue before it can trust md_busy.
         if (armed && (run != md_busy))
            md_err <= 1'b1;
         if (md_stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      armed_n = armed;
      unique case (state)
         IDLE: begin
            if (issue) begin
               state_n = RUN;
               cnt_n   = e_md_op[1] ? DIV_LAT : MULT_LAT;
               armed_n = 1'b1;
            end
         end
         RUN: begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1)
               state_n = IDLE;
         end
      endcase
   end

   // Outputs. The unit acts on op 4/5 without start, so anything that is
   // not a live HI/LO op must present the idle code 7 (never 6).
   always_comb begin
      md_start = issue;
      md_op    = 3'd7;
      if (go && (e_md_op != 3'd6))
         md_op = e_md_op;
      md_stall = d_md_use & (run | issue);
   end

   assign md_cycles_left = cnt;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed and random checks of md_ctrl against a
// timeline model (issue cycle + latency) kept in the bench.
module tb_md_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        d_md_use = 1'b0;
   logic        e_md_valid = 1'b0;
   logic [2:0]  e_md_op = 3'd0;
   logic        e_flush = 1'b0;
   logic        md_busy = 1'b0;
   logic        md_start;
   logic [2:0]  md_op;
   logic        md_stall;
   logic [3:0]  md_cycles_left;
   logic        md_err;
   logic [15:0] stall_cnt;

   md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk            (clk),
      .reset          (reset),
      .d_md_use       (d_md_use),
      .e_md_valid     (e_md_valid),
      .e_md_op        (e_md_op),
      .e_flush        (e_flush),
      .md_busy        (md_busy),
      .md_start       (md_start),
      .md_op          (md_op),
      .md_stall       (md_stall),
      .md_cycles_left (md_cycles_left),
      .md_err         (md_err),
      .stall_cnt      (stall_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Model: an op issued in cycle iss_cyc keeps the unit busy for
   // cycles iss_cyc+1 .. iss_cyc+iss_lat.
   int cyc = 0;
   int iss_cyc = -1000;
   int iss_lat = 1;
   bit armed_m = 1'b0;
   bit err_m = 1'b0;
   int stall_m = 0;
   bit drop = 1'b0;
   bit force_busy = 1'b0;

   function automatic bit m_run();
      return (cyc > iss_cyc) && (cyc <= iss_cyc + iss_lat);
   endfunction

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(bit u, bit v, logic [2:0] op, bit f);
      d_md_use   = u;
      e_md_valid = v;
      e_md_op    = op;
      e_flush    = f;
   endtask

   task automatic mreset();
      iss_cyc = -1000;
      armed_m = 1'b0;
      err_m   = 1'b0;
      stall_m = 0;
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_start"}, 16'(md_start), 16'd0);
      chk({tag, "_op"}, 16'(md_op), 16'd7);
      chk({tag, "_stall"}, 16'(md_stall), 16'd0);
      chk({tag, "_left"}, 16'(md_cycles_left), 16'd0);
      chk({tag, "_err"}, 16'(md_err), 16'd0);
      chk({tag, "_scnt"}, stall_cnt, 16'd0);
   endtask

   // One clock cycle: drive busy, check at negedge, advance model.
   task automatic step();
      bit run, go, iss, stl;
      logic [2:0] op_e;
      int left;
      run = m_run();
      md_busy = force_busy |
                (run && !(drop && (cyc == iss_cyc + iss_lat)));
      go   = e_md_valid && !e_flush;
      iss  = go && !run && (e_md_op <= 3'd3);
      stl  = d_md_use && (run || iss);
      op_e = go ? e_md_op : 3'd7;
      left = run ? (iss_cyc + iss_lat - cyc + 1) : 0;
      @(negedge clk);
      chk("md_start", 16'(md_start), 16'(iss));
      chk("md_op", 16'(md_op), 16'(op_e));
      chk("md_stall", 16'(md_stall), 16'(stl));
      chk("md_cycles_left", 16'(md_cycles_left), 16'(left));
      chk("md_err", 16'(md_err), 16'(err_m));
      chk("stall_cnt", stall_cnt, 16'(stall_m));
      @(posedge clk);
      if (stl && (stall_m < 65535))
         stall_m++;
      if (armed_m && (run != md_busy))
         err_m = 1'b1;
      if (iss) begin
         iss_cyc = cyc;
         iss_lat = e_md_op[1] ? 10 : 5;
         armed_m = 1'b1;
      end
      cyc++;
      #1;
   endtask

   initial begin
      // Reset held 3 cycles, unit busy flag driven high throughout.
      force_busy = 1'b1;
      md_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_reset_vals("rst");
         @(posedge clk);
         cyc++;
      end
      #1 reset = 1'b1;
      repeat (3) step();
      force_busy = 1'b0;

      // mult with a dependent mflo waiting in D.
      drv(1, 1, 3'd0, 0);
      step();
      drv(1, 0, 3'd0, 0);
      repeat (6) step();
      chk("mult_stall_cnt", stall_cnt, 16'd6);
      chk("mult_idle_left", 16'(md_cycles_left), 16'd0);
      drv(0, 0, 3'd0, 0);
      step();

      // divu without dependency, then div back-to-back at N+11.
      drv(0, 1, 3'd3, 0);
      step();
      drv(0, 0, 3'd0, 0);
      repeat (10) step();
      chk("divu_done_left", 16'(md_cycles_left), 16'd0);
      drv(0, 1, 3'd2, 0);
      #1 chk("div2_start", 16'(md_start), 16'd1);
      step();
      drv(0, 0, 3'd0, 0);
      repeat (11) step();

      // mthi in IDLE, then the same op flushed.
      drv(1, 1, 3'd4, 0);
      #1 chk("mthi_op", 16'(md_op), 16'd4);
      chk("mthi_start", 16'(md_start), 16'd0);
      step();
      drv(1, 1, 3'd4, 1);
      #1 chk("mthi_flush_op", 16'(md_op), 16'd7);
      step();
      drv(1, 0, 3'd0, 0);
      #1 chk("mthi_idle_stall", 16'(md_stall), 16'd0);
      step();
      drv(0, 0, 3'd0, 0);

      // Unit drops busy one cycle early.
      drop = 1'b1;
      drv(0, 1, 3'd0, 0);
      step();
      drv(0, 0, 3'd0, 0);
      repeat (6) step();
      chk("early_drop_err", 16'(md_err), 16'd1);
      drop = 1'b0;
      repeat (5) step();
      chk("err_sticky", 16'(md_err), 16'd1);

      // Reset asserted in the 3rd RUN cycle of a div.
      drv(1, 1, 3'd2, 0);
      step();
      drv(1, 0, 3'd0, 0);
      repeat (2) step();
      #1 reset = 1'b0;
      #1 chk_reset_vals("async_rst");
      mreset();
      @(posedge clk);
      cyc++;
      #1 reset = 1'b1;
      drv(0, 1, 3'd0, 0);
      step();
      drv(0, 0, 3'd0, 0);
      #1 chk("post_rst_left", 16'(md_cycles_left), 16'd5);
      repeat (6) step();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drv(bit'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0),
             3'($urandom_range(0, 5)),
             ($urandom_range(0, 5) == 0));
         step();
      end
      drv(0, 0, 3'd0, 0);
      repeat (12) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
